// File: rtl/shift_reg_univ_pkg.sv
// Shared constants for the universal shift register: operation codes and FSM encoding.
package shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'd0;
    localparam logic [2:0] MODE_SHL   = 3'd1;
    localparam logic [2:0] MODE_SHR   = 3'd2;
    localparam logic [2:0] MODE_ROL   = 3'd3;
    localparam logic [2:0] MODE_ROR   = 3'd4;
    localparam logic [2:0] MODE_LOAD  = 3'd5;
    localparam logic [2:0] MODE_CLEAR = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_reg_univ_if.sv
// Command, data and status bundle for shift_reg_univ; the controller drives the master side.
interface shift_reg_univ_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             Start;
    logic [2:0]       Mode;
    logic [CNT_W-1:0] Count;
    logic [WIDTH-1:0] D_par;
    logic             SI_L;
    logic             SI_R;
    logic [WIDTH-1:0] Q;
    logic             SO_L;
    logic             SO_R;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, Mode, Count, D_par, SI_L, SI_R,
        input  Q, SO_L, SO_R, Busy, Done
    );

    modport slave (
        input  Start, Mode, Count, D_par, SI_L, SI_R,
        output Q, SO_L, SO_R, Busy, Done
    );
endinterface

// File: rtl/shift_reg_univ_datapath.sv
// Combinational next-state of the shift register for one application of the latched operation.
module shift_reg_datapath
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       op,
    input  logic             si_l,
    input  logic             si_r,
    input  logic [WIDTH-1:0] d_par,
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        q_next = q;
        case (op)
            MODE_SHL:   q_next = {q[WIDTH-2:0], si_r};
            MODE_SHR:   q_next = {si_l, q[WIDTH-1:1]};
            MODE_ROL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:   q_next = {q[0], q[WIDTH-1:1]};
            MODE_LOAD:  q_next = d_par;
            MODE_CLEAR: q_next = '0;
            // HOLD and the reserved code both leave Q alone
            default:    q_next = q;
        endcase
    end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: Start/Busy/Done controller that applies the latched op Count times.
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic           Clk,
    input  logic           Rst,
    shift_reg_univ_if.slave bus
);

    state_t           state;
    logic [2:0]       op;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic             busy;
    logic             done;

    shift_reg_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .q      (q),
        .op     (op),
        .si_l   (bus.SI_L),
        .si_r   (bus.SI_R),
        .d_par  (bus.D_par),
        .q_next (q_next)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            op        <= MODE_HOLD;
            remaining <= '0;
            q         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        op        <= bus.Mode;
                        remaining <= bus.Count;
                        // a zero count skips RUN entirely and still reports completion
                        if (bus.Count != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    q         <= q_next;
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Q    = q;
    assign bus.SO_L = q[WIDTH-1];
    assign bus.SO_R = q[0];
    assign bus.Busy = busy;
    assign bus.Done = done;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ: an 8-bit instance for most scenarios and a 4-bit one for legacy SHR.
module tb_shift_reg_univ;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 Clk = ~Clk;

    shift_reg_univ_if #(.WIDTH(8), .CNT_W(4)) if8 ();
    shift_reg_univ_if #(.WIDTH(4), .CNT_W(4)) if4 ();

    shift_reg_univ #(.WIDTH(8), .CNT_W(4)) dut8 (
        .Clk (Clk),
        .Rst (Rst),
        .bus (if8)
    );

    shift_reg_univ #(.WIDTH(4), .CNT_W(4)) dut4 (
        .Clk (Clk),
        .Rst (Rst),
        .bus (if4)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        if8.Start = 1'b1;
        if8.Mode  = 3'($urandom_range(0, 7));
        if8.Count = 4'($urandom_range(1, 15));
        if8.D_par = 8'($urandom);
        if8.SI_L  = 1'b1;
        if8.SI_R  = 1'b1;
        tick();
        if8.D_par = 8'($urandom);
        tick();
        n_cmp++; if (if8.Q !== 8'h00) begin n_err++; $display("FAIL reset_q: got %h expected 00", if8.Q); end
        n_cmp++; if (if8.SO_L !== 1'b0) begin n_err++; $display("FAIL reset_so_l: got %b expected 0", if8.SO_L); end
        n_cmp++; if (if8.SO_R !== 1'b0) begin n_err++; $display("FAIL reset_so_r: got %b expected 0", if8.SO_R); end
        n_cmp++; if (if8.Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", if8.Busy); end
        n_cmp++; if (if8.Done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", if8.Done); end
        n_cmp++; if (if4.Q !== 4'h0) begin n_err++; $display("FAIL reset_q4: got %h expected 0", if4.Q); end
        if8.Start = 1'b0;
        if8.SI_L  = 1'b0;
        if8.SI_R  = 1'b0;
        Rst = 1'b0;
        tick();
    endtask

    task automatic test_load();
        if8.Start = 1'b1;
        if8.Mode  = 3'd5;
        if8.Count = 4'd1;
        if8.D_par = 8'hA5;
        tick();
        if8.Start = 1'b0;
        n_cmp++; if (if8.Busy !== 1'b1) begin n_err++; $display("FAIL load_busy: got %b expected 1", if8.Busy); end
        n_cmp++; if (if8.Q !== 8'h00) begin n_err++; $display("FAIL load_q_before: got %h expected 00", if8.Q); end
        tick();
        n_cmp++; if (if8.Q !== 8'hA5) begin n_err++; $display("FAIL load_q: got %h expected a5", if8.Q); end
        n_cmp++; if (if8.Busy !== 1'b0) begin n_err++; $display("FAIL load_busy_end: got %b expected 0", if8.Busy); end
        n_cmp++; if (if8.Done !== 1'b1) begin n_err++; $display("FAIL load_done: got %b expected 1", if8.Done); end
        tick();
        n_cmp++; if (if8.Done !== 1'b0) begin n_err++; $display("FAIL load_done_pulse: got %b expected 0", if8.Done); end
    endtask

    task automatic test_shl();
        logic [7:0] exp_q [3];
        exp_q[0] = 8'h4B;
        exp_q[1] = 8'h97;
        exp_q[2] = 8'h2F;
        if8.Start = 1'b1;
        if8.Mode  = 3'd1;
        if8.Count = 4'd3;
        if8.SI_R  = 1'b1;
        tick();
        if8.Start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (if8.Q !== exp_q[i]) begin n_err++; $display("FAIL shl_q[%0d]: got %h expected %h", i, if8.Q, exp_q[i]); end
            if (i == 1) begin
                n_cmp++; if (if8.SO_L !== 1'b1 || if8.SO_R !== 1'b1) begin n_err++; $display("FAIL shl_so: got %b%b expected 11", if8.SO_L, if8.SO_R); end
            end
        end
        n_cmp++; if (if8.Done !== 1'b1) begin n_err++; $display("FAIL shl_done: got %b expected 1", if8.Done); end
        if8.SI_R = 1'b0;
        tick();
    endtask

    task automatic test_shr4();
        logic [3:0] exp_q [4];
        logic       si [4];
        exp_q[0] = 4'b1000; si[0] = 1'b1;
        exp_q[1] = 4'b0100; si[1] = 1'b0;
        exp_q[2] = 4'b1010; si[2] = 1'b1;
        exp_q[3] = 4'b0101; si[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if4.Start = 1'b1;
            if4.Mode  = 3'd2;
            if4.Count = 4'd1;
            if4.SI_L  = si[i];
            tick();
            if4.Start = 1'b0;
            tick();
            n_cmp++; if (if4.Q !== exp_q[i]) begin n_err++; $display("FAIL shr4_q[%0d]: got %b expected %b", i, if4.Q, exp_q[i]); end
            tick();
        end
        n_cmp++; if (if4.SO_R !== 1'b1 || if4.SO_L !== 1'b0) begin n_err++; $display("FAIL shr4_so: got L%b R%b expected L0 R1", if4.SO_L, if4.SO_R); end
    endtask

    task automatic test_ror_ignore_start();
        int busy_cycles = 0;
        if8.Start = 1'b1;
        if8.Mode  = 3'd5;
        if8.Count = 4'd1;
        if8.D_par = 8'h96;
        tick();
        if8.Start = 1'b0;
        tick();
        tick();
        if8.Start = 1'b1;
        if8.Mode  = 3'd4;
        if8.Count = 4'd8;
        tick();
        if8.Start = 1'b0;
        if (if8.Busy === 1'b1) busy_cycles++;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                if8.Start = 1'b1;
                if8.Mode  = 3'd6;
                if8.Count = 4'd1;
            end
            tick();
            if8.Start = 1'b0;
            if (if8.Busy === 1'b1) busy_cycles++;
            if (i == 0) begin
                n_cmp++; if (if8.Q !== 8'h4B) begin n_err++; $display("FAIL ror_first: got %h expected 4b", if8.Q); end
            end
        end
        n_cmp++; if (busy_cycles !== 8) begin n_err++; $display("FAIL ror_busy_cycles: got %0d expected 8", busy_cycles); end
        n_cmp++; if (if8.Q !== 8'h96) begin n_err++; $display("FAIL ror_q: got %h expected 96", if8.Q); end
        n_cmp++; if (if8.Done !== 1'b1) begin n_err++; $display("FAIL ror_done: got %b expected 1", if8.Done); end
        tick();
        tick();
        n_cmp++; if (if8.Q !== 8'h96 || if8.Busy !== 1'b0) begin n_err++; $display("FAIL ror_clear_ignored: got q=%h busy=%b expected q=96 busy=0", if8.Q, if8.Busy); end
    endtask

    task automatic test_zero_count();
        if8.Start = 1'b1;
        if8.Mode  = 3'd6;
        if8.Count = 4'd0;
        tick();
        if8.Start = 1'b0;
        n_cmp++; if (if8.Done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b expected 1", if8.Done); end
        n_cmp++; if (if8.Busy !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %b expected 0", if8.Busy); end
        n_cmp++; if (if8.Q !== 8'h96) begin n_err++; $display("FAIL zero_q: got %h expected 96", if8.Q); end
        tick();
        n_cmp++; if (if8.Done !== 1'b0 || if8.Busy !== 1'b0) begin n_err++; $display("FAIL zero_after: got done=%b busy=%b expected 0 0", if8.Done, if8.Busy); end
        tick();
    endtask

    task automatic test_reserved_mode();
        if8.Start = 1'b1;
        if8.Mode  = 3'd7;
        if8.Count = 4'd2;
        tick();
        if8.Start = 1'b0;
        tick();
        tick();
        n_cmp++; if (if8.Done !== 1'b1 || if8.Q !== 8'h96) begin n_err++; $display("FAIL reserved: got done=%b q=%h expected done=1 q=96", if8.Done, if8.Q); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int done_seen = 0;
        if8.Start = 1'b1;
        if8.Mode  = 3'd2;
        if8.Count = 4'd10;
        if8.SI_L  = 1'b1;
        tick();
        if8.Start = 1'b0;
        tick();
        tick();
        tick();
        n_cmp++; if (if8.Q !== 8'hF2 || if8.Busy !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: got q=%h busy=%b expected q=f2 busy=1", if8.Q, if8.Busy); end
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        n_cmp++; if (if8.Q !== 8'h00) begin n_err++; $display("FAIL rstmid_q: got %h expected 00", if8.Q); end
        n_cmp++; if (if8.Busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", if8.Busy); end
        for (int i = 0; i < 12; i++) begin
            if (if8.Done === 1'b1 || if8.Busy === 1'b1) done_seen++;
            tick();
        end
        n_cmp++; if (done_seen !== 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d active cycles expected 0", done_seen); end
        if8.SI_L = 1'b0;
    endtask

    task automatic test_back_to_back();
        if8.Start = 1'b1;
        if8.Mode  = 3'd5;
        if8.Count = 4'd1;
        if8.D_par = 8'h3C;
        tick();
        tick();
        n_cmp++; if (if8.Q !== 8'h3C || if8.Done !== 1'b1) begin n_err++; $display("FAIL b2b_first: got q=%h done=%b expected q=3c done=1", if8.Q, if8.Done); end
        tick();
        n_cmp++; if (if8.Busy !== 1'b0) begin n_err++; $display("FAIL b2b_fin_ignore: got busy=%b expected 0", if8.Busy); end
        tick();
        if8.Start = 1'b0;
        if8.D_par = 8'hC3;
        n_cmp++; if (if8.Busy !== 1'b1) begin n_err++; $display("FAIL b2b_retrigger: got busy=%b expected 1", if8.Busy); end
        tick();
        n_cmp++; if (if8.Q !== 8'hC3 || if8.Done !== 1'b1) begin n_err++; $display("FAIL b2b_second: got q=%h done=%b expected q=c3 done=1", if8.Q, if8.Done); end
        tick();
    endtask

    initial begin
        if8.Start = 1'b0; if8.Mode = 3'd0; if8.Count = '0; if8.D_par = '0; if8.SI_L = 1'b0; if8.SI_R = 1'b0;
        if4.Start = 1'b0; if4.Mode = 3'd0; if4.Count = '0; if4.D_par = '0; if4.SI_L = 1'b0; if4.SI_R = 1'b0;
        #1;
        test_reset();
        test_load();
        test_shl();
        test_shr4();
        test_ror_ignore_start();
        test_zero_count();
        test_reserved_mode();
        test_reset_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
